// File: rtl/cpu6_pc_checker_pkg.sv
// Shared state and fail-cause encodings for the cpu6 PC checkpoint monitor.
package cpu6_pc_checker_pkg;

    typedef enum logic [1:0] {
        CPU6_CHK_ST_IDLE = 2'd0,
        CPU6_CHK_ST_RUN  = 2'd1,
        CPU6_CHK_ST_PASS = 2'd2,
        CPU6_CHK_ST_FAIL = 2'd3
    } chk_state_e;

    typedef enum logic [1:0] {
        CPU6_CHK_CAUSE_NONE     = 2'd0,
        CPU6_CHK_CAUSE_MISMATCH = 2'd1,
        CPU6_CHK_CAUSE_MISSING  = 2'd2,
        CPU6_CHK_CAUSE_TIMEOUT  = 2'd3
    } chk_cause_e;

endpackage

// File: rtl/cpu6_pc_checker_cmp.sv
// One checkpoint slot: PC match against the programmed PC and masked value compare.
module cpu6_chk_cmp
    import cpu6_pc_checker_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_en,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_chk_pc,
    input  logic [XLEN-1:0] i_obs,
    input  logic [XLEN-1:0] i_exp,
    input  logic [XLEN-1:0] i_mask,
    output logic            o_match,
    output logic            o_ok
);

    assign o_match = i_en && (i_pc == i_chk_pc);
    // Only bits with mask=1 take part in the comparison.
    assign o_ok    = ((i_obs & i_mask) == (i_exp & i_mask));

endmodule

// File: rtl/cpu6_pc_checker.sv
// Checkpoint monitor for the committed PC stream: sticky pass/fail verdict with timeout.
// Optional macro CPU6_PC_CHECKER_SIM_MSG_EN adds simulation-only verdict messages.
module cpu6_pc_checker
    import cpu6_pc_checker_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NCHK  = 4,
    parameter int TMO_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_sample_valid,
    input  logic [XLEN-1:0]          i_pc,
    input  logic [NCHK*XLEN-1:0]     i_obs_data,
    input  logic [NCHK-1:0]          i_chk_en,
    input  logic [NCHK-1:0]          i_chk_final,
    input  logic [NCHK*XLEN-1:0]     i_chk_pc,
    input  logic [NCHK*XLEN-1:0]     i_chk_exp,
    input  logic [NCHK*XLEN-1:0]     i_chk_mask,
    input  logic [TMO_W-1:0]         i_tmo_limit,
    output logic                     o_busy,
    output logic                     o_pass,
    output logic                     o_fail,
    output logic [1:0]               o_fail_cause,
    output logic [$clog2(NCHK)-1:0]  o_fail_idx,
    output logic [XLEN-1:0]          o_fail_obs,
    output logic [NCHK-1:0]          o_hit_mask,
    output logic [TMO_W-1:0]         o_sample_cnt
);

    localparam int IDX_W = $clog2(NCHK);

    chk_state_e        r_state, r_state_next;
    chk_cause_e        r_cause, r_cause_next;
    logic [IDX_W-1:0]  r_idx, r_idx_next;
    logic [XLEN-1:0]   r_obs, r_obs_next;
    logic [NCHK-1:0]   r_hit, r_hit_next;
    logic [TMO_W-1:0]  r_cnt, r_cnt_next;

    logic [NCHK-1:0]   w_match, w_ok, w_bad, w_good, w_hit_sum, w_unhit;
    logic              w_final;
    logic [IDX_W-1:0]  w_bad_idx, w_unhit_idx;
    logic [XLEN-1:0]   w_bad_obs;
    logic [TMO_W-1:0]  w_cnt_inc;
    logic              w_tmo_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NCHK; gi++) begin : g_cmp
            cpu6_chk_cmp #(.XLEN(XLEN)) u_cmp (
                .i_en     (i_chk_en[gi]),
                .i_pc     (i_pc),
                .i_chk_pc (i_chk_pc[gi*XLEN +: XLEN]),
                .i_obs    (i_obs_data[gi*XLEN +: XLEN]),
                .i_exp    (i_chk_exp[gi*XLEN +: XLEN]),
                .i_mask   (i_chk_mask[gi*XLEN +: XLEN]),
                .o_match  (w_match[gi]),
                .o_ok     (w_ok[gi])
            );
        end
    endgenerate

    assign w_bad     = w_match & ~w_ok;
    assign w_good    = w_match & w_ok;
    // Hits from the deciding sample itself count toward completeness.
    assign w_hit_sum = r_hit | w_good;
    assign w_unhit   = i_chk_en & ~i_chk_final & ~w_hit_sum;
    assign w_final   = |(w_good & i_chk_final);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + TMO_W'(1);
    assign w_tmo_hit = (i_tmo_limit != '0) && (w_cnt_inc == i_tmo_limit);

    // Descending scan so the lowest index is the one left standing.
    always_comb begin
        w_bad_idx   = '0;
        w_bad_obs   = '0;
        w_unhit_idx = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (w_bad[i]) begin
                w_bad_idx = IDX_W'(i);
                w_bad_obs = i_obs_data[i*XLEN +: XLEN];
            end
            if (w_unhit[i]) begin
                w_unhit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        r_state_next = r_state;
        r_cause_next = r_cause;
        r_idx_next   = r_idx;
        r_obs_next   = r_obs;
        r_hit_next   = r_hit;
        r_cnt_next   = r_cnt;
        if (i_start) begin
            r_state_next = CPU6_CHK_ST_RUN;
            r_cause_next = CPU6_CHK_CAUSE_NONE;
            r_idx_next   = '0;
            r_obs_next   = '0;
            r_hit_next   = '0;
            r_cnt_next   = '0;
        end else if (r_state == CPU6_CHK_ST_RUN && i_sample_valid) begin
            r_cnt_next = w_cnt_inc;
            if (|w_bad) begin
                r_state_next = CPU6_CHK_ST_FAIL;
                r_cause_next = CPU6_CHK_CAUSE_MISMATCH;
                r_idx_next   = w_bad_idx;
                r_obs_next   = w_bad_obs;
            end else begin
                r_hit_next = w_hit_sum;
                if (w_final) begin
                    if (|w_unhit) begin
                        r_state_next = CPU6_CHK_ST_FAIL;
                        r_cause_next = CPU6_CHK_CAUSE_MISSING;
                        r_idx_next   = w_unhit_idx;
                        r_obs_next   = '0;
                    end else begin
                        r_state_next = CPU6_CHK_ST_PASS;
                    end
                end else if (w_tmo_hit) begin
                    r_state_next = CPU6_CHK_ST_FAIL;
                    r_cause_next = CPU6_CHK_CAUSE_TIMEOUT;
                    r_idx_next   = '0;
                    r_obs_next   = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= CPU6_CHK_ST_IDLE;
            r_cause <= CPU6_CHK_CAUSE_NONE;
            r_idx   <= '0;
            r_obs   <= '0;
            r_hit   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_next;
            r_cause <= r_cause_next;
            r_idx   <= r_idx_next;
            r_obs   <= r_obs_next;
            r_hit   <= r_hit_next;
            r_cnt   <= r_cnt_next;
        end
    end

    assign o_busy       = (r_state == CPU6_CHK_ST_RUN);
    assign o_pass       = (r_state == CPU6_CHK_ST_PASS);
    assign o_fail       = (r_state == CPU6_CHK_ST_FAIL);
    assign o_fail_cause = r_cause;
    assign o_fail_idx   = r_idx;
    assign o_fail_obs   = r_obs;
    assign o_hit_mask   = r_hit;
    assign o_sample_cnt = r_cnt;

`ifdef CPU6_PC_CHECKER_SIM_MSG_EN
    always @(posedge i_clk) begin
        if (!i_reset && r_state != CPU6_CHK_ST_PASS && r_state_next == CPU6_CHK_ST_PASS) begin
            $display("cpu6_pc_checker SUCCESS");
        end
        if (!i_reset && r_state != CPU6_CHK_ST_FAIL && r_state_next == CPU6_CHK_ST_FAIL) begin
            $display("cpu6_pc_checker FAILED cause=%0d idx=%0d pc=%h obs=%h",
                     r_cause_next, r_idx_next, i_pc, r_obs_next);
            $stop;
        end
    end
`else
    // Verdict is reported on the output ports only.
`endif

endmodule

// File: tb/tb_cpu6_pc_checker.sv
// Directed bench for cpu6_pc_checker with a rule-level reference model checked every cycle.
module tb_cpu6_pc_checker;

    localparam int XLEN  = 32;
    localparam int NCHK  = 4;
    localparam int TMO_W = 16;
    localparam int IDX_W = 2;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PASS = 2;
    localparam int S_FAIL = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 sample_valid = 1'b0;
    logic [XLEN-1:0]      pc = '0;
    logic [NCHK*XLEN-1:0] obs_data = '0;
    logic [NCHK-1:0]      chk_en = '0;
    logic [NCHK-1:0]      chk_final = '0;
    logic [NCHK*XLEN-1:0] chk_pc = '0;
    logic [NCHK*XLEN-1:0] chk_exp = '0;
    logic [NCHK*XLEN-1:0] chk_mask = '0;
    logic [TMO_W-1:0]     tmo_limit = '0;

    logic                 busy, pass, fail;
    logic [1:0]           fail_cause;
    logic [IDX_W-1:0]     fail_idx;
    logic [XLEN-1:0]      fail_obs;
    logic [NCHK-1:0]      hit_mask;
    logic [TMO_W-1:0]     sample_cnt;

    cpu6_pc_checker #(.XLEN(XLEN), .NCHK(NCHK), .TMO_W(TMO_W)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_sample_valid (sample_valid),
        .i_pc           (pc),
        .i_obs_data     (obs_data),
        .i_chk_en       (chk_en),
        .i_chk_final    (chk_final),
        .i_chk_pc       (chk_pc),
        .i_chk_exp      (chk_exp),
        .i_chk_mask     (chk_mask),
        .i_tmo_limit    (tmo_limit),
        .o_busy         (busy),
        .o_pass         (pass),
        .o_fail         (fail),
        .o_fail_cause   (fail_cause),
        .o_fail_idx     (fail_idx),
        .o_fail_obs     (fail_obs),
        .o_hit_mask     (hit_mask),
        .o_sample_cnt   (sample_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int              m_state = S_IDLE;
    int              m_cause = 0;
    int              m_idx   = 0;
    int              m_cnt   = 0;
    logic [XLEN-1:0] m_obs   = '0;
    logic [NCHK-1:0] m_hit   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_state = S_IDLE; m_cause = 0; m_idx = 0; m_cnt = 0; m_obs = '0; m_hit = '0;
    endtask

    task automatic model_step();
        int              first_bad;
        int              unhit;
        bit              fin;
        logic [XLEN-1:0] o, e, mk;
        if (reset) begin
            model_clear();
            return;
        end
        if (start) begin
            model_clear();
            m_state = S_RUN;
            return;
        end
        if (m_state != S_RUN || !sample_valid) return;
        m_cnt = (m_cnt + 1 > (1 << TMO_W) - 1) ? (1 << TMO_W) - 1 : m_cnt + 1;
        first_bad = -1;
        fin = 1'b0;
        for (int i = 0; i < NCHK; i++) begin
            if (chk_en[i] && pc == chk_pc[i*XLEN +: XLEN]) begin
                o  = obs_data[i*XLEN +: XLEN];
                e  = chk_exp[i*XLEN +: XLEN];
                mk = chk_mask[i*XLEN +: XLEN];
                if (((o ^ e) & mk) != '0) begin
                    if (first_bad < 0) first_bad = i;
                end else begin
                    m_hit[i] = 1'b1;
                    if (chk_final[i]) fin = 1'b1;
                end
            end
        end
        if (first_bad >= 0) begin
            // A mismatch discards any hits from the same sample.
            for (int i = 0; i < NCHK; i++)
                if (chk_en[i] && pc == chk_pc[i*XLEN +: XLEN] && !dut_prev_hit(i)) m_hit[i] = 1'b0;
            m_state = S_FAIL; m_cause = 1; m_idx = first_bad;
            m_obs = obs_data[first_bad*XLEN +: XLEN];
            return;
        end
        if (fin) begin
            unhit = -1;
            for (int i = 0; i < NCHK; i++)
                if (unhit < 0 && chk_en[i] && !chk_final[i] && !m_hit[i]) unhit = i;
            if (unhit < 0) m_state = S_PASS;
            else begin
                m_state = S_FAIL; m_cause = 2; m_idx = unhit; m_obs = '0;
            end
            return;
        end
        if (tmo_limit != '0 && m_cnt == int'(tmo_limit)) begin
            m_state = S_FAIL; m_cause = 3; m_idx = 0; m_obs = '0;
        end
    endtask

    // Hit set as it stood before the current sample, for undoing a mismatching sample.
    logic [NCHK-1:0] m_hit_before = '0;
    function automatic bit dut_prev_hit(input int i);
        return m_hit_before[i];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m_hit_before = m_hit;
            model_step();
            @(negedge clk);
            if (reset) model_clear();
            check("busy",       64'(busy),       64'(m_state == S_RUN));
            check("pass",       64'(pass),       64'(m_state == S_PASS));
            check("fail",       64'(fail),       64'(m_state == S_FAIL));
            check("fail_cause", 64'(fail_cause), 64'(m_cause));
            check("fail_idx",   64'(fail_idx),   64'(m_idx));
            check("fail_obs",   64'(fail_obs),   64'(m_obs));
            check("hit_mask",   64'(hit_mask),   64'(m_hit));
            check("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        tick(); start = 1'b1; sample_valid = 1'b0;
        tick(); start = 1'b0;
        $display("tx start");
    endtask

    task automatic send(input logic [XLEN-1:0] p);
        tick(); sample_valid = 1'b1; pc = p;
        $display("tx sample pc=%h", p);
    endtask

    task automatic idle();
        tick(); sample_valid = 1'b0;
    endtask

    task automatic set_chk(input int i, input bit en, input bit fin,
                           input logic [XLEN-1:0] p, input logic [XLEN-1:0] e,
                           input logic [XLEN-1:0] mk);
        chk_en[i] = en;
        chk_final[i] = fin;
        chk_pc[i*XLEN +: XLEN] = p;
        chk_exp[i*XLEN +: XLEN] = e;
        chk_mask[i*XLEN +: XLEN] = mk;
    endtask

    task automatic set_obs(input int i, input logic [XLEN-1:0] v);
        obs_data[i*XLEN +: XLEN] = v;
    endtask

    task automatic base_cfg();
        set_chk(0, 1, 0, 32'h1c, 32'hffffffee, 32'hffffffff);
        set_chk(1, 1, 1, 32'h30, 32'hffffffee, 32'hffffffff);
        set_chk(2, 0, 0, 32'h0, 32'h0, 32'h0);
        set_chk(3, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < NCHK; i++) set_obs(i, 32'hffffffee);
        tmo_limit = '0;
    endtask

    task automatic csrrc_flow();
        do_start();
        send(32'h10); send(32'h14); send(32'h1c); send(32'h20); send(32'h30);
        idle();
        @(negedge clk);
        check("csrrc_pass", 64'(pass), 64'd1);
        check("csrrc_hit",  64'(hit_mask), 64'b11);
        check("csrrc_cnt",  64'(sample_cnt), 64'd5);
        $display("tx verdict pass=%0d fail=%0d", pass, fail);
    endtask

    initial begin
        base_cfg();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);
        check("rst_hit",  64'(hit_mask), 64'd0);
        tick(); reset = 1'b0;

        // Sample in IDLE is ignored
        send(32'h1c); idle();
        @(negedge clk);
        check("idle_ignore_hit", 64'(hit_mask), 64'd0);

        // CSRRC pass flow
        do_start();
        @(negedge clk);
        check("start_busy", 64'(busy), 64'd1);
        send(32'h10); send(32'h14); send(32'h1c); send(32'h20); send(32'h30);
        idle();
        @(negedge clk);
        check("s1_pass", 64'(pass), 64'd1);
        check("s1_busy", 64'(busy), 64'd0);
        check("s1_hit",  64'(hit_mask), 64'b11);

        // Mismatch at chk0
        set_obs(0, 32'hffffffef);
        do_start();
        send(32'h10); send(32'h1c); idle();
        @(negedge clk);
        check("mm_fail",  64'(fail), 64'd1);
        check("mm_cause", 64'(fail_cause), 64'd1);
        check("mm_idx",   64'(fail_idx), 64'd0);
        check("mm_obs",   64'(fail_obs), 64'hffffffef);
        send(32'h30); idle();
        @(negedge clk);
        check("mm_no_pass", 64'(pass), 64'd0);

        // Missing checkpoint
        set_obs(0, 32'hffffffee);
        do_start();
        send(32'h10); send(32'h30); idle();
        @(negedge clk);
        check("miss_cause", 64'(fail_cause), 64'd2);
        check("miss_idx",   64'(fail_idx), 64'd0);
        check("miss_obs",   64'(fail_obs), 64'd0);
        check("miss_hit",   64'(hit_mask), 64'b10);

        // Timeout after the 8th sample
        tmo_limit = 16'd8;
        do_start();
        for (int k = 0; k < 8; k++) send(32'h100 + 32'(4 * k));
        @(negedge clk);
        check("tmo_busy7", 64'(busy), 64'd1);
        check("tmo_cnt7",  64'(sample_cnt), 64'd7);
        idle();
        @(negedge clk);
        check("tmo_cause", 64'(fail_cause), 64'd3);
        check("tmo_idx",   64'(fail_idx), 64'd0);
        check("tmo_cnt",   64'(sample_cnt), 64'd8);
        tmo_limit = '0;

        // Mask and lowest-failing-index priority
        set_chk(2, 1, 0, 32'h30, 32'h1234abcd, 32'h0000ffff);
        set_chk(3, 1, 0, 32'h30, 32'h0, 32'hffffffff);
        set_obs(2, 32'hffffabcd);
        set_obs(3, 32'h5);
        do_start();
        send(32'h1c); send(32'h30); idle();
        @(negedge clk);
        check("prio_cause", 64'(fail_cause), 64'd1);
        check("prio_idx",   64'(fail_idx), 64'd3);
        check("prio_obs",   64'(fail_obs), 64'd5);
        check("prio_hit",   64'(hit_mask), 64'b0001);
        set_obs(3, 32'h0);
        do_start();
        send(32'h1c); send(32'h30); idle();
        @(negedge clk);
        check("mask_pass", 64'(pass), 64'd1);
        check("mask_hit",  64'(hit_mask), 64'b1111);

        // Restart with a sample in the same cycle drops the sample
        base_cfg();
        do_start();
        send(32'h1c);
        tick(); start = 1'b1; sample_valid = 1'b1; pc = 32'h30;
        tick(); start = 1'b0; sample_valid = 1'b0;
        @(negedge clk);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_hit",  64'(hit_mask), 64'd0);
        check("restart_cnt",  64'(sample_cnt), 64'd0);

        // Reset mid-run, then rerun the pass flow
        send(32'h10); send(32'h1c);
        tick(); sample_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_hit",  64'(hit_mask), 64'd0);
        check("mid_rst_cnt",  64'(sample_cnt), 64'd0);
        tick(); reset = 1'b0;
        csrrc_flow();

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
